// File: rtl/seq_alu.sv
// Registered ALU with a load/clear control FSM, an accumulator mode, and a
// multi-cycle unsigned shift-add multiplier with busy/done handshake.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       in_sel,
  input  logic [3:0]       out_sel,
  input  logic             acc_mode,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             busy,
  output logic             done,
  output logic [1:0]       curr_state,
  output logic [1:0]       next_state
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] LAST = SW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    MUL  = 2'b10,
    HOLD = 2'b11
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_PASS = 4'd10;
  localparam logic [3:0] OP_CMP  = 4'd11;

  state_t               state_q, state_d;
  logic                 ready_q;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [3:0]           op_q;
  logic [2*WIDTH-1:0]   prod_q;
  logic [SW-1:0]        cnt_q;
  logic [WIDTH-1:0]     out_q, out_hi_q;
  logic                 carry_q, zero_q, ovf_q, done_q;

  logic                 clr, ld;
  logic [WIDTH-1:0]     res_d;
  logic                 carry_d, zero_d, ovf_d;
  logic [WIDTH:0]       sum, diff, shl_ext, shr_ext;
  logic signed [WIDTH:0] sra_ext;
  logic [SW-1:0]        sh;
  logic [WIDTH:0]       mul_add;
  logic [2*WIDTH-1:0]   prod_nxt;

  // clear beats load; a load is refused on the first edge after reset release
  always_comb begin
    clr = 1'b0;
    ld  = 1'b0;
    casez (in_sel)
      3'b??1:  clr = 1'b1;
      3'b?10:  ld  = ready_q;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (clr) state_d = IDLE;
            else if (ld) state_d = (out_sel == OP_MUL) ? MUL : EXEC;
      EXEC: state_d = clr ? IDLE : HOLD;
      MUL:  if (clr) state_d = IDLE;
            else if (cnt_q == LAST) state_d = HOLD;
      HOLD: if (clr) state_d = IDLE;
            else if (ld) state_d = (out_sel == OP_MUL) ? MUL : EXEC;
      default: state_d = IDLE;
    endcase
  end

  // Shifts use a one-bit extension so the last bit shifted out lands in a
  // fixed position; a zero shift amount leaves that bit at 0.
  assign sh      = b_q[SW-1:0];
  assign sum     = {1'b0, a_q} + {1'b0, b_q};
  assign diff    = {1'b0, a_q} - {1'b0, b_q};
  assign shl_ext = {1'b0, a_q} << sh;
  assign shr_ext = {a_q, 1'b0} >> sh;
  assign sra_ext = $signed({a_q, 1'b0}) >>> sh;

  always_comb begin
    res_d   = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_d   = sum[WIDTH-1:0];
        carry_d = sum[WIDTH];
        ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        res_d   = diff[WIDTH-1:0];
        carry_d = diff[WIDTH];
        ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND:  res_d = a_q & b_q;
      OP_OR:   res_d = a_q | b_q;
      OP_XOR:  res_d = a_q ^ b_q;
      OP_NOT:  res_d = ~a_q;
      OP_SHL: begin
        res_d   = shl_ext[WIDTH-1:0];
        carry_d = shl_ext[WIDTH];
      end
      OP_SHR: begin
        res_d   = shr_ext[WIDTH:1];
        carry_d = shr_ext[0];
      end
      OP_SRA: begin
        res_d   = sra_ext[WIDTH:1];
        carry_d = sra_ext[0];
      end
      OP_PASS: res_d = b_q;
      OP_CMP: begin
        res_d   = out_q;
        carry_d = diff[WIDTH];
        ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      default: res_d = '0;
    endcase
    zero_d = (op_q == OP_CMP) ? (diff[WIDTH-1:0] == '0) : (res_d == '0);
  end

  // Multiplier step: upper half accumulates A when the current multiplier
  // bit (prod_q[0]) is set, then the whole product shifts right by one.
  assign mul_add  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_q} : '0);
  assign prod_nxt = {mul_add, prod_q[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
      out_hi_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      if (clr) begin
        out_q    <= '0;
        out_hi_q <= '0;
        carry_q  <= 1'b0;
        zero_q   <= 1'b0;
        ovf_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE, HOLD: if (ld) begin
            a_q    <= acc_mode ? out_q : num1;
            b_q    <= num2;
            op_q   <= out_sel;
            prod_q <= {{WIDTH{1'b0}}, num2};
            cnt_q  <= '0;
          end
          EXEC: begin
            out_q    <= res_d;
            out_hi_q <= '0;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            done_q   <= 1'b1;
          end
          MUL: begin
            prod_q <= prod_nxt;
            cnt_q  <= cnt_q + SW'(1);
            if (cnt_q == LAST) begin
              out_q    <= prod_nxt[WIDTH-1:0];
              out_hi_q <= prod_nxt[2*WIDTH-1:WIDTH];
              carry_q  <= 1'b0;
              zero_q   <= (prod_nxt == '0);
              ovf_q    <= 1'b0;
              done_q   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out        = out_q;
  assign out_hi     = out_hi_q;
  assign carry      = carry_q;
  assign zero       = zero_q;
  assign ovf        = ovf_q;
  assign done       = done_q;
  assign busy       = (state_q == MUL);
  assign curr_state = state_q;
  assign next_state = state_d;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed loads push hand-computed results;
// a negedge monitor pops one entry per done pulse and compares.
module tb_seq_alu;

  localparam int W = 8;
  localparam logic [2:0] LD  = 3'b010;
  localparam logic [2:0] CLR = 3'b001;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [2:0]   in_sel = 3'b000;
  logic [3:0]   out_sel = 4'd0;
  logic         acc_mode = 1'b0;
  logic [W-1:0] num1 = '0;
  logic [W-1:0] num2 = '0;
  logic [W-1:0] out, out_hi;
  logic         carry, zero, ovf, busy, done;
  logic [1:0]   curr_state, next_state;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_sel(in_sel), .out_sel(out_sel),
    .acc_mode(acc_mode), .num1(num1), .num2(num2), .out(out), .out_hi(out_hi),
    .carry(carry), .zero(zero), .ovf(ovf), .busy(busy), .done(done),
    .curr_state(curr_state), .next_state(next_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] o;
    logic [W-1:0] h;
    logic         c;
    logic         z;
    logic         v;
    int           due;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  int    checks = 0;
  int    failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
      end else begin
        exp_t  e;
        string nm;
        e  = q.pop_front();
        nm = nq.pop_front();
        chk({nm, ".out"},    32'(out),        32'(e.o));
        chk({nm, ".out_hi"}, 32'(out_hi),     32'(e.h));
        chk({nm, ".carry"},  32'(carry),      32'(e.c));
        chk({nm, ".zero"},   32'(zero),       32'(e.z));
        chk({nm, ".ovf"},    32'(ovf),        32'(e.v));
        chk({nm, ".state"},  32'(curr_state), 32'd3);
        chk({nm, ".cycle"},  32'(cyc),        32'(e.due));
      end
    end
  end

  // Called at a negedge; load is presented for exactly one rising edge.
  task automatic issue(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic acc, input bit push,
                       input logic [W-1:0] eo, input logic [W-1:0] eh,
                       input logic ec, input logic ez, input logic ev);
    exp_t e;
    in_sel   = LD;
    out_sel  = op;
    num1     = a;
    num2     = b;
    acc_mode = acc;
    if (push) begin
      e = '{o: eo, h: eh, c: ec, z: ez, v: ev, due: cyc + ((op == 4'd9) ? W + 1 : 2)};
      q.push_back(e);
      nq.push_back(nm);
    end
    #1 chk({nm, ".next_state"}, 32'(next_state), (op == 4'd9) ? 32'd2 : 32'd1);
    @(negedge clk);
    in_sel   = 3'b000;
    acc_mode = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s.timeout actual=no_done required=done", nm);
    end
  endtask

  task automatic run_op(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic acc, input logic [W-1:0] eo,
                        input logic ec, input logic ez, input logic ev);
    issue(nm, op, a, b, acc, 1'b1, eo, '0, ec, ez, ev);
    wait_done(nm);
  endtask

  task automatic run_mul(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eo, input logic [W-1:0] eh,
                         input logic ez, input bit ign);
    issue(nm, 4'd9, a, b, 1'b0, 1'b1, eo, eh, 1'b0, ez, 1'b0);
    for (int i = 0; i < W; i++) begin
      chk({nm, ".busy"}, 32'(busy), 32'd1);
      if (ign && i == 3) begin
        in_sel  = LD;
        out_sel = 4'd0;
        num1    = 8'h01;
        num2    = 8'h01;
      end else begin
        in_sel = 3'b000;
      end
      @(negedge clk);
    end
    in_sel = 3'b000;
    chk({nm, ".busy_end"}, 32'(busy), 32'd0);
    chk({nm, ".done"},     32'(done), 32'd1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1;
    chk("rst.out",    32'(out),        32'd0);
    chk("rst.out_hi", 32'(out_hi),     32'd0);
    chk("rst.flags",  32'({carry, zero, ovf}), 32'd0);
    chk("rst.busy",   32'(busy),       32'd0);
    chk("rst.done",   32'(done),       32'd0);
    chk("rst.state",  32'(curr_state), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add",      4'd0,  8'h57, 8'h1A, 1'b0, 8'h71, 1'b0, 1'b0, 1'b0);
    run_op("acc_add",  4'd0,  8'hEE, 8'h0F, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1);
    run_op("sub",      4'd1,  8'h57, 8'h1A, 1'b0, 8'h3D, 1'b0, 1'b0, 1'b0);
    run_op("cmp",      4'd11, 8'h1A, 8'h57, 1'b0, 8'h3D, 1'b1, 1'b0, 1'b0);
    run_mul("mul", 8'h57, 8'h1A, 8'hD6, 8'h08, 1'b0, 1'b1);
    run_op("sra",      4'd8,  8'h90, 8'h03, 1'b0, 8'hF2, 1'b0, 1'b0, 1'b0);
    run_op("shl",      4'd6,  8'h81, 8'h09, 1'b0, 8'h02, 1'b1, 1'b0, 1'b0);
    run_op("shr0",     4'd7,  8'h81, 8'h00, 1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
    run_op("shr",      4'd7,  8'h0F, 8'h02, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0);
    run_op("xor",      4'd4,  8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    run_op("not",      4'd5,  8'h0F, 8'h33, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0);
    run_op("and",      4'd2,  8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
    run_op("or",       4'd3,  8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0);
    run_op("pass",     4'd10, 8'h11, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap", 4'd0,  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    run_op("sub_ovf",  4'd1,  8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1);
    run_op("op13",     4'd13, 8'h12, 8'h34, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    run_mul("mul_zero", 8'h00, 8'h5A, 8'h00, 8'h00, 1'b1, 1'b0);
    run_mul("mul_max",  8'hFF, 8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0);
    run_op("cmp_eq",   4'd11, 8'h42, 8'h42, 1'b0, 8'h01, 1'b0, 1'b1, 1'b0);

    // Abort a multiply in its fourth busy cycle: no result, no done.
    issue("abort", 4'd9, 8'h57, 8'h1A, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    in_sel = CLR;
    #1 chk("abort.next_state", 32'(next_state), 32'd0);
    @(negedge clk);
    in_sel = 3'b000;
    chk("abort.state",  32'(curr_state), 32'd0);
    chk("abort.out",    32'(out),        32'd0);
    chk("abort.out_hi", 32'(out_hi),     32'd0);
    chk("abort.busy",   32'(busy),       32'd0);
    chk("abort.flags",  32'({carry, zero, ovf}), 32'd0);
    repeat (12) @(negedge clk);

    // Async reset in the middle of an EXEC cycle.
    run_op("pre_rst", 4'd0, 8'h57, 8'h1A, 1'b0, 8'h71, 1'b0, 1'b0, 1'b0);
    issue("mid_exec", 4'd0, 8'h10, 8'h20, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("mid_exec.state", 32'(curr_state), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst.out",   32'(out),        32'd0);
    chk("mid_rst.flags", 32'({carry, zero, ovf}), 32'd0);
    chk("mid_rst.done",  32'(done),       32'd0);
    chk("mid_rst.state", 32'(curr_state), 32'd0);
    @(negedge clk);

    // Load held across release: the first edge must ignore it.
    begin
      exp_t e;
      rst_n   = 1'b1;
      in_sel  = LD;
      out_sel = 4'd0;
      num1    = 8'h01;
      num2    = 8'h02;
      e = '{o: 8'h03, h: 8'h00, c: 1'b0, z: 1'b0, v: 1'b0, due: cyc + 3};
      q.push_back(e);
      nq.push_back("post_rst");
    end
    @(negedge clk);
    chk("post_rst.first_edge", 32'(curr_state), 32'd0);
    @(negedge clk);
    chk("post_rst.second_edge", 32'(curr_state), 32'd1);
    in_sel = 3'b000;
    wait_done("post_rst");
    repeat (3) @(negedge clk);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
